// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types and request classification for the data-memory responder
package dmem_responder_pkg;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W} mem_size_t;
  typedef enum logic [2:0] {IDLE, RD, RDATA, WR, RESP} dmem_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] wdata;
  } dmem_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dmem_resp_t;
  function automatic logic align_err(input logic [1:0] off, input logic [1:0] size);
    return size == 2'd3 || (size == MEM_H && off[0]) || (size == MEM_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response valid-ready channels between MEM stage and responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/bram_1r1w.sv
// bram_1r1w: word-wide block RAM, one registered read port and one write port, no byte enables
module bram_1r1w #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end
endmodule

// File: rtl/dmem_responder_lane_align.sv
// dmem_responder_lane_align: load lane extraction/extension and sub-word store merge
module dmem_responder_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  assign sh = {off_i, 3'b000};
  assign b = 8'(word_i >> sh);
  assign h = off_i[1] ? word_i[31:16] : word_i[15:0];
  assign load_o = size_i == MEM_B ? {{24{b[7] & ~unsigned_i}}, b}
                : size_i == MEM_H ? {{16{h[15] & ~unsigned_i}}, h} : word_i;
  // full-word stores fall through to wdata so one path feeds every BRAM write
  assign store_o = size_i == MEM_B ? (word_i & ~(32'hFF << sh)) | (32'(wdata_i[7:0]) << sh)
                 : size_i == MEM_H ? (off_i[1] ? {wdata_i[15:0], word_i[15:0]} : {word_i[31:16], wdata_i[15:0]})
                 : wdata_i;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressable load/store responder over a byte-enable-less BRAM (RMW for SB/SH)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_WORDS)
) (
  input logic clk,
  input logic rst,
  dmem_responder_if.slave bus
);
  dmem_state_t           state_q;
  dmem_req_t             req_d;
  dmem_resp_t            resp_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [1:0]            off_q, size_q;
  logic                  we_q, uns_q, err_d, wr_en;
  logic [31:0]           wdata_q, rd_data, ld_data, st_data;
  assign req_d = '{addr: bus.req_addr, we: bus.req_we, size: bus.req_size,
                   unsigned_ld: bus.req_unsigned, wdata: bus.req_wdata};
  assign err_d = align_err(req_d.addr[1:0], req_d.size) || (req_d.addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign bus.req_ready  = state_q == IDLE && !rst;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = resp_q.rdata;
  assign bus.resp_err   = resp_q.err;
  // reset must suppress a write already in flight
  assign wr_en = !rst && (state_q == WR || (state_q == RDATA && we_q));
  dmem_responder_lane_align u_align (
    .word_i(rd_data), .off_i(off_q), .size_i(size_q), .unsigned_i(uns_q),
    .wdata_i(wdata_q), .load_o(ld_data), .store_o(st_data)
  );
  bram_1r1w #(.DEPTH(MEM_WORDS), .AW(ADDR_WIDTH), .W(32)) u_bram (
    .clk(clk), .rd_addr_i(waddr_q), .rd_data_o(rd_data),
    .wr_en_i(wr_en), .wr_addr_i(waddr_q), .wr_data_i(st_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      resp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          waddr_q <= req_d.addr[ADDR_WIDTH+1:2];
          off_q   <= req_d.addr[1:0];
          size_q  <= req_d.size;
          we_q    <= req_d.we;
          uns_q   <= req_d.unsigned_ld;
          wdata_q <= req_d.wdata;
          resp_q  <= '{rdata: 32'd0, err: err_d};
          state_q <= err_d ? RESP : (req_d.we && req_d.size == MEM_W) ? WR : RD;
        end
        RD: state_q <= RDATA;
        RDATA: begin
          resp_q.rdata <= we_q ? 32'd0 : ld_data;
          state_q <= RESP;
        end
        WR: state_q <= RESP;
        RESP: if (bus.resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table, stall/reset sequences and randomized model check
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus();
  dmem_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vecs[$];
  logic [31:0] model[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called #1 after an edge with resp_ready high; returns with the response consumed
  task automatic xfer(input logic [31:0] addr, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err, output int lat);
    int w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    bus.req_addr = addr; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    rdata = bus.resp_rdata;
    err = bus.resp_err;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] word, input int off, input int size, input logic uns);
    logic [31:0] v;
    if (size == 0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (word >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else v = word;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] word, input int off, input int size, input logic [31:0] wd);
    if (size == 0) return (word & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
    if (size == 1) return (word & ~(32'hFFFF << (16 * (off / 2)))) | ((wd & 32'hFFFF) << (16 * (off / 2)));
    return wd;
  endfunction

  initial begin
    logic [31:0] rd, addr, wd, exp_rd;
    logic er, we, uns, exp_er;
    logic [1:0] size;
    int lat, exp_lat, w;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

    vecs.push_back('{32'h10,   1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 2});
    vecs.push_back('{32'h10,   1'b0, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3});
    vecs.push_back('{32'h13,   1'b0, 2'd0, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0, 3});
    vecs.push_back('{32'h13,   1'b0, 2'd0, 1'b1, 32'h0,        32'h000000DE, 1'b0, 3});
    vecs.push_back('{32'h10,   1'b0, 2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0, 3});
    vecs.push_back('{32'h12,   1'b0, 2'd1, 1'b1, 32'h0,        32'h0000DEAD, 1'b0, 3});
    vecs.push_back('{32'h11,   1'b1, 2'd0, 1'b0, 32'hFFFFFF5A, 32'h0,        1'b0, 3});
    vecs.push_back('{32'h10,   1'b0, 2'd2, 1'b0, 32'h0,        32'hDEAD5AEF, 1'b0, 3});
    vecs.push_back('{32'h12,   1'b1, 2'd1, 1'b0, 32'hABCD1234, 32'h0,        1'b0, 3});
    vecs.push_back('{32'h10,   1'b0, 2'd2, 1'b0, 32'h0,        32'h12345AEF, 1'b0, 3});
    vecs.push_back('{32'h10,   1'b0, 2'd0, 1'b0, 32'h0,        32'hFFFFFFEF, 1'b0, 3});
    vecs.push_back('{32'h02,   1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1, 1});
    vecs.push_back('{32'h01,   1'b1, 2'd1, 1'b0, 32'hFFFF,     32'h0,        1'b1, 1});
    vecs.push_back('{32'h4000, 1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1, 1});
    vecs.push_back('{32'h10,   1'b1, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 1});
    vecs.push_back('{32'h10,   1'b0, 2'd2, 1'b0, 32'h0,        32'h12345AEF, 1'b0, 3});
    vecs.push_back('{32'h00,   1'b1, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 2});
    vecs.push_back('{32'h4000, 1'b1, 2'd2, 1'b0, 32'h00000BAD, 32'h0,        1'b1, 1});
    vecs.push_back('{32'h00,   1'b0, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 3});
    vecs.push_back('{32'h20,   1'b1, 2'd2, 1'b0, 32'h0,        32'h0,        1'b0, 2});

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_err", 32'(bus.resp_err), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      xfer(vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].wdata, rd, er, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].err));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // stalled response must hold steady and block new requests
    bus.resp_ready = 1'b0;
    bus.req_addr = 32'h10; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    w = 1;
    while (!bus.resp_valid && w < 12) begin
      @(posedge clk); #1; w++;
    end
    check("stall latency", 32'(w), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d resp_valid", i), 32'(bus.resp_valid), 32'd1);
      check($sformatf("stall%0d rdata", i), bus.resp_rdata, 32'h12345AEF);
      check($sformatf("stall%0d req_ready", i), 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("release resp_valid", 32'(bus.resp_valid), 32'd0);
    check("release req_ready", 32'(bus.req_ready), 32'd1);

    // reset landing in the WR cycle of a store must drop the write
    bus.req_addr = 32'h20; bus.req_we = 1'b1; bus.req_size = 2'd2;
    bus.req_wdata = 32'h11111111; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst%0d resp_valid", i), 32'(bus.resp_valid), 32'd0);
      check($sformatf("rst%0d req_ready", i), 32'(bus.req_ready), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(32'h20, 1'b0, 2'd2, 1'b0, 32'h0, rd, er, lat);
    check("post-rst 0x20 rdata", rd, 32'h0);
    check("post-rst 0x20 latency", 32'(lat), 32'd3);
    xfer(32'h10, 1'b0, 2'd2, 1'b0, 32'h0, rd, er, lat);
    check("post-rst 0x10 rdata", rd, 32'h12345AEF);

    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      xfer(32'(i * 4), 1'b1, 2'd2, 1'b0, model[i], rd, er, lat);
      check($sformatf("init%0d err", i), 32'(er), 32'd0);
    end
    for (int n = 0; n < 300; n++) begin
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(14, 31));
      size = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_er = size == 2'd3 || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0) || addr >= 32'h4000;
      exp_rd = 32'h0;
      if (exp_er) exp_lat = 1;
      else if (we) begin
        model[addr / 4] = m_store(model[addr / 4], int'(addr % 4), int'(size), wd);
        exp_lat = size == 2'd2 ? 2 : 3;
      end else begin
        exp_rd = m_load(model[addr / 4], int'(addr % 4), int'(size), uns);
        exp_lat = 3;
      end
      xfer(addr, we, size, uns, wd, rd, er, lat);
      check($sformatf("rnd%0d rdata a=%h s=%0d we=%0d", n, addr, size, we), rd, exp_rd);
      check($sformatf("rnd%0d err", n), 32'(er), 32'(exp_er));
      check($sformatf("rnd%0d latency", n), 32'(lat), 32'(exp_lat));
    end
    for (int i = 0; i < 16; i++) begin
      xfer(32'(i * 4), 1'b0, 2'd2, 1'b0, 32'h0, rd, er, lat);
      check($sformatf("final word%0d", i), rd, model[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
